// File: rtl/spi_master_tx.sv
// SPI mode-0 master: pulls bytes from a sync FIFO and shifts them out MSB first
// while capturing miso; back-to-back bytes keep cs_n low, otherwise a CS gap follows.
module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rde,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, GAP} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] gap_q, gap_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rxs_q, rxs_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       rde_q, rde_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rxs_d      = rxs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rde_d      = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      // The read strobe is registered, so the FIFO data arrives one cycle after
      // the strobe; the strobe cycle itself is spent waiting before FETCH.
      IDLE: begin
        sclk_d = 1'b0;
        cs_n_d = 1'b1;
        mosi_d = 1'b0;
        if (rde_q)                    state_d = FETCH;
        else if (en && !fifo_empty)   rde_d   = 1'b1;
      end
      FETCH: begin
        tx_d    = fifo_dout;
        mosi_d  = fifo_dout[7];
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (rde_q) begin
          state_d = FETCH;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rxs_d = {rxs_q[6:0], miso};
          end else if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end else begin
            rx_data_d  = rxs_q;
            rx_valid_d = 1'b1;
            if (en && !fifo_empty) begin
              rde_d = 1'b1;
            end else begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              gap_d   = '0;
              state_d = GAP;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      gap_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rxs_q      <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rde_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rxs_q      <= rxs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rde_q      <= rde_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign fifo_rde = rde_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: registered-output FIFO model, miso loopback,
// negedge monitor that logs strobes, sclk edges and received bytes.
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rde;
  logic       miso;
  logic       sclk, mosi, cs_n, rx_valid, busy;
  logic [7:0] rx_data;

  logic       loop = 1'b1;
  logic       miso_fix = 1'b0;
  assign miso = loop ? mosi : miso_fix;

  always #5 clk = ~clk;

  spi_master_tx #(.CLK_DIV(4), .CS_GAP(2)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rde(fifo_rde), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  // FIFO model: dout registered on the read strobe
  logic [7:0] mem [0:31];
  int wr = 0;
  int rd = 0;
  assign fifo_empty = (wr == rd);
  always @(posedge clk)
    if (fifo_rde && rd != wr) begin
      fifo_dout <= mem[rd];
      rd <= rd + 1;
    end

  task automatic push(input logic [7:0] b);
    mem[wr] = b;
    wr = wr + 1;
  endtask

  int checks = 0;
  int errors = 0;

  logic       clr_mon = 1'b0;
  int         rde_cnt, rx_cnt, rises, cs_low, gap_cyc, cs_rises, mosi_hi;
  logic       rx_seen, prev_sclk, prev_cs;
  logic [7:0] mosi_bits;
  logic [7:0] rx_log [0:7];
  int         bad_rde = 0;
  int         sclk_bad = 0;

  always @(negedge clk) begin
    if (clr_mon) begin
      rde_cnt = 0; rx_cnt = 0; rises = 0; cs_low = 0; gap_cyc = 0;
      cs_rises = 0; mosi_hi = 0; rx_seen = 1'b0; mosi_bits = 8'h00;
    end else begin
      if (sclk && !prev_sclk) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], mosi};
      end
      if (fifo_rde) rde_cnt++;
      if (rx_valid) begin
        if (rx_cnt < 8) rx_log[rx_cnt] = rx_data;
        rx_cnt++;
        rx_seen = 1'b1;
      end
      if (!cs_n) cs_low++;
      if (cs_n && busy && rx_seen) gap_cyc++;
      if (cs_n && !prev_cs) cs_rises++;
      if (mosi) mosi_hi++;
    end
    if (fifo_rde && fifo_empty) bad_rde++;
    if (sclk && cs_n) sclk_bad++;
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 clr_mon = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string nm);
    int k = 0;
    while (rx_cnt < n && k < 3000) begin @(negedge clk); k++; end
    checks++;
    if (rx_cnt < n) begin
      errors++;
      $display("FAIL %s rx timeout: got %0d bytes, want %0d", nm, rx_cnt, n);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    @(negedge clk);
    while (busy && k < 3000) begin @(negedge clk); k++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s idle timeout: busy=%b want 0", nm, busy);
    end
  endtask

  task automatic wait_rises(input int n, input string nm);
    int k = 0;
    while (rises < n && k < 3000) begin @(negedge clk); k++; end
    checks++;
    if (rises < n) begin
      errors++;
      $display("FAIL %s sclk timeout: got %0d rises, want %0d", nm, rises, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sclk, cs_n, mosi, fifo_rde, rx_valid, busy} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_ctl: sclk,cs_n,mosi,rde,rxv,busy=%b want 010000",
               {sclk, cs_n, mosi, fifo_rde, rx_valid, busy});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    clear_mon();
    push(8'h54);
    en = 1'b1;
    wait_rx(1, "single");
    wait_idle("single");
    checks++;
    if (rde_cnt !== 1) begin errors++; $display("FAIL single_rde: got %0d want 1", rde_cnt); end
    checks++;
    if (rises !== 8) begin errors++; $display("FAIL single_rises: got %0d want 8", rises); end
    checks++;
    if (mosi_bits !== 8'h54) begin errors++; $display("FAIL single_mosi: got %h want 54", mosi_bits); end
    checks++;
    if (cs_low !== 64) begin errors++; $display("FAIL single_cs_low: got %0d want 64", cs_low); end
    checks++;
    if (rx_cnt !== 1 || rx_log[0] !== 8'h54) begin
      errors++; $display("FAIL single_rx: got %0d x %h want 1 x 54", rx_cnt, rx_log[0]);
    end
    checks++;
    if (gap_cyc !== 2) begin errors++; $display("FAIL single_gap: got %0d want 2", gap_cyc); end
  endtask

  task automatic test_burst();
    en = 1'b0;
    clear_mon();
    push(8'hA5); push(8'h3C); push(8'hFF);
    en = 1'b1;
    wait_rx(3, "burst");
    wait_idle("burst");
    checks++;
    if (rde_cnt !== 3) begin errors++; $display("FAIL burst_rde: got %0d want 3", rde_cnt); end
    checks++;
    if (cs_rises !== 1) begin errors++; $display("FAIL burst_cs_breaks: got %0d want 1", cs_rises); end
    checks++;
    if (rises !== 24) begin errors++; $display("FAIL burst_rises: got %0d want 24", rises); end
    checks++;
    if (rx_log[0] !== 8'hA5 || rx_log[1] !== 8'h3C || rx_log[2] !== 8'hFF) begin
      errors++;
      $display("FAIL burst_rx: got %h %h %h want a5 3c ff", rx_log[0], rx_log[1], rx_log[2]);
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    clear_mon();
    push(8'h11); push(8'h96);
    repeat (20) @(negedge clk);
    checks++;
    if (rde_cnt !== 0 || cs_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL en_off: rde=%0d cs_n=%b busy=%b want 0 1 0", rde_cnt, cs_n, busy);
    end
    en = 1'b1;
    wait_rises(4, "en_drop");
    en = 1'b0;
    wait_rx(1, "en_drop");
    wait_idle("en_drop");
    repeat (10) @(negedge clk);
    checks++;
    if (rde_cnt !== 1 || rx_cnt !== 1) begin
      errors++; $display("FAIL en_drop_rde: rde=%0d rx=%0d want 1 1", rde_cnt, rx_cnt);
    end
    checks++;
    if (rx_log[0] !== 8'h11 || (wr - rd) !== 1) begin
      errors++; $display("FAIL en_drop_data: rx=%h left=%0d want 11 1", rx_log[0], wr - rd);
    end
  endtask

  task automatic test_rst_mid();
    clear_mon();
    en = 1'b1;
    wait_rises(5, "rst_mid");
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({sclk, cs_n, mosi, fifo_rde, rx_valid, busy} !== 6'b010000) begin
      errors++;
      $display("FAIL rst_mid_ctl: sclk,cs_n,mosi,rde,rxv,busy=%b want 010000",
               {sclk, cs_n, mosi, fifo_rde, rx_valid, busy});
    end
    push(8'h5A);
    @(negedge clk);
    rst = 1'b0;
    wait_rx(1, "rst_mid");
    wait_idle("rst_mid");
    checks++;
    if (rx_cnt !== 1 || rx_log[0] !== 8'h5A) begin
      errors++; $display("FAIL rst_mid_rx: got %0d x %h want 1 x 5a", rx_cnt, rx_log[0]);
    end
  endtask

  task automatic test_receive();
    en = 1'b0;
    loop = 1'b0;
    miso_fix = 1'b1;
    clear_mon();
    push(8'h00);
    en = 1'b1;
    wait_rx(1, "receive");
    wait_idle("receive");
    checks++;
    if (rx_log[0] !== 8'hFF) begin errors++; $display("FAIL recv_rx: got %h want ff", rx_log[0]); end
    checks++;
    if (mosi_hi !== 0) begin errors++; $display("FAIL recv_mosi: got %0d high cycles want 0", mosi_hi); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_enable();
    test_rst_mid();
    test_receive();
    checks++;
    if (bad_rde !== 0) begin errors++; $display("FAIL rde_when_empty: got %0d want 0", bad_rde); end
    checks++;
    if (sclk_bad !== 0) begin errors++; $display("FAIL sclk_while_cs_high: got %0d want 0", sclk_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
